visitor_gate_controller: RTL and testbench

Sequencing controller for the visitor-counting gate. Filters the two IR beam sensors, decodes their ordered blocking pattern into entry/exit events, and maintains the occupancy count against a capacity limit. Drives the door lock and room light and flags malformed sequences. It replaces the free-running decode inside the counter datapath with an explicit, debounced, timeout-protected state machine.

---
 rtl/visitor_gate_controller.sv | 218 +++++++++++++++++++++
 tb/tb_visitor_gate_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/visitor_gate_controller.sv
// Visitor gate sequencer: synchronizes and debounces two IR beams, decodes
// ordered beam patterns into entry/exit commits and keeps a saturating occupancy count.
module visitor_gate_controller #(
    parameter int CAPACITY       = 50,
    parameter int DEBOUNCE       = 3,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_sensor1,
    input  logic       ir_sensor2,
    input  logic       clear,
    output logic [7:0] curr_visitor,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       full,
    output logic       door_lock,
    output logic       light,
    output logic       seq_error
);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      CAP      = 8'(CAPACITY);
    localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_B,
        OUT_A,
        OUT_B,
        WAIT_CLEAR
    } state_t;

    logic [1:0] raw;
    logic [1:0] filt;
    logic       s1;
    logic       s2;

    assign raw = {ir_sensor2, ir_sensor1};
    assign s1  = filt[0];
    assign s2  = filt[1];

    // Per-beam 2-flop synchronizer followed by a stability counter; the filtered
    // value only follows the synced value after DEBOUNCE consecutive differing cycles.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic       meta_reg;
            logic       sync_reg;
            logic       filt_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    filt_reg <= 1'b0;
                    cnt_reg  <= 4'd0;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                    if (sync_reg != filt_reg) begin
                        if (cnt_reg == DB_LAST) begin
                            filt_reg <= sync_reg;
                            cnt_reg  <= 4'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= 4'd0;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    state_t          state_reg;
    state_t          state_next;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   timer_next;
    logic            timed_state;
    logic            commit_entry;
    logic            commit_exit;
    logic            fsm_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = '0;
        commit_entry = 1'b0;
        commit_exit  = 1'b0;
        fsm_error    = 1'b0;
        timed_state  = (state_reg inside {IN_A, IN_B, OUT_A, OUT_B});

        // A stalled sequence is abandoned before any normal transition is honoured.
        if (timed_state && (timer_reg == TO_LIMIT)) begin
            state_next = WAIT_CLEAR;
            fsm_error  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s1 && !s2) begin
                        state_next = IN_A;
                    end else if (!s1 && s2) begin
                        state_next = OUT_A;
                    end else if (s1 && s2) begin
                        state_next = WAIT_CLEAR;
                        fsm_error  = 1'b1;
                    end
                end
                IN_A: begin
                    if (s2) begin
                        state_next = IN_B;
                    end else if (!s1) begin
                        state_next = IDLE;
                    end
                end
                IN_B: begin
                    if (!s1 && !s2) begin
                        state_next   = IDLE;
                        commit_entry = 1'b1;
                    end
                end
                OUT_A: begin
                    if (s1) begin
                        state_next = OUT_B;
                    end else if (!s2) begin
                        state_next = IDLE;
                    end
                end
                OUT_B: begin
                    if (!s1 && !s2) begin
                        state_next  = IDLE;
                        commit_exit = 1'b1;
                    end
                end
                WAIT_CLEAR: begin
                    if (!s1 && !s2) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (timed_state && (state_next == state_reg)) begin
                timer_next = timer_reg + 1'b1;
            end
        end
    end

    logic [7:0] count_reg;
    logic [7:0] count_next;
    logic       entry_reg;
    logic       entry_next;
    logic       exit_reg;
    logic       exit_next;
    logic       err_reg;
    logic       err_next;

    // clear wins over a same-cycle commit and silently drops it.
    always_comb begin
        count_next = count_reg;
        entry_next = 1'b0;
        exit_next  = 1'b0;
        err_next   = fsm_error;
        if (clear) begin
            count_next = 8'd0;
        end else if (commit_entry) begin
            if (count_reg < CAP) begin
                count_next = count_reg + 8'd1;
                entry_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (commit_exit) begin
            if (count_reg != 8'd0) begin
                count_next = count_reg - 8'd1;
                exit_next  = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 8'd0;
            entry_reg <= 1'b0;
            exit_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            entry_reg <= entry_next;
            exit_reg  <= exit_next;
            err_reg   <= err_next;
        end
    end

    assign curr_visitor = count_reg;
    assign entry_pulse  = entry_reg;
    assign exit_pulse   = exit_reg;
    assign seq_error    = err_reg;
    assign full         = (count_reg >= CAP);
    assign door_lock    = full;
    assign light        = (count_reg != 8'd0);

endmodule

// File: tb/tb_visitor_gate_controller.sv
// Scoreboard bench: two gate controllers (default parameters, and a small
// capacity/short-timeout variant) with expected pulse events queued per instance.
module tb_visitor_gate_controller;

    localparam int K_ENTRY = 0;
    localparam int K_EXIT  = 1;
    localparam int K_ERR   = 2;
    localparam int K_MULTI = 3;

    typedef struct {
        int kind;
        int cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] ir1;
    logic [1:0] ir2;
    logic [1:0] clr;

    logic [7:0] cv_a, cv_b;
    logic       en_a, ex_a, er_a, full_a, lock_a, light_a;
    logic       en_b, ex_b, er_b, full_b, lock_b, light_b;

    int  checks   = 0;
    int  failures = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    always #5 clk = ~clk;

    visitor_gate_controller dut_a (
        .clk          (clk),
        .reset        (rst_n[0]),
        .ir_sensor1   (ir1[0]),
        .ir_sensor2   (ir2[0]),
        .clear        (clr[0]),
        .curr_visitor (cv_a),
        .entry_pulse  (en_a),
        .exit_pulse   (ex_a),
        .full         (full_a),
        .door_lock    (lock_a),
        .light        (light_a),
        .seq_error    (er_a)
    );

    visitor_gate_controller #(
        .CAPACITY       (2),
        .DEBOUNCE       (3),
        .TIMEOUT_CYCLES (20)
    ) dut_b (
        .clk          (clk),
        .reset        (rst_n[1]),
        .ir_sensor1   (ir1[1]),
        .ir_sensor2   (ir2[1]),
        .clear        (clr[1]),
        .curr_visitor (cv_b),
        .entry_pulse  (en_b),
        .exit_pulse   (ex_b),
        .full         (full_b),
        .door_lock    (lock_b),
        .light        (light_b),
        .seq_error    (er_b)
    );

    function automatic string kname(input int k);
        case (k)
            K_ENTRY: return "entry";
            K_EXIT:  return "exit";
            K_ERR:   return "seq_error";
            default: return "multiple";
        endcase
    endfunction

    task automatic expect_ev(input int inst, input int kind, input int cnt);
        ev_t e;
        e.kind = kind;
        e.cnt  = cnt;
        if (inst == 0) q_a.push_back(e);
        else           q_b.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Every cycle with any pulse high is one observed transaction.
    task automatic observe(input int inst, input logic en, input logic ex,
                           input logic er, input logic [7:0] c);
        ev_t e;
        int  n;
        int  ak;
        bit  empty;
        n = int'(en) + int'(ex) + int'(er);
        if (n == 0) return;
        ak = (n > 1) ? K_MULTI : (en ? K_ENTRY : (ex ? K_EXIT : K_ERR));
        checks++;
        empty = (inst == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
            failures++;
            $display("FAIL dut%0d_unexpected_event: got %s count=%0d, required no event",
                     inst, kname(ak), c);
            return;
        end
        if (inst == 0) e = q_a.pop_front();
        else           e = q_b.pop_front();
        if (ak != e.kind || int'(c) != e.cnt) begin
            failures++;
            $display("FAIL dut%0d_event: got %s count=%0d, required %s count=%0d",
                     inst, kname(ak), c, kname(e.kind), e.cnt);
        end else begin
            $display("dut%0d event %s count=%0d ok", inst, kname(ak), c);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n[0]) observe(0, en_a, ex_a, er_a, cv_a);
        if (rst_n[1]) observe(1, en_b, ex_b, er_b, cv_b);
    end

    task automatic phase(input int inst, input logic a, input logic b, input int n);
        ir1[inst] = a;
        ir2[inst] = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic entry_seq(input int inst);
        phase(inst, 1'b1, 1'b0, 10);
        phase(inst, 1'b0, 1'b1, 10);
        phase(inst, 1'b0, 1'b0, 10);
    endtask

    task automatic exit_seq(input int inst);
        phase(inst, 1'b0, 1'b1, 10);
        phase(inst, 1'b1, 1'b0, 10);
        phase(inst, 1'b0, 1'b0, 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 2'b00;
        ir1   = 2'b00;
        ir2   = 2'b00;
        clr   = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_count_in_reset", int'(cv_a), 0);
        rst_n = 2'b11;
        @(negedge clk);
        chk("reset_count", int'(cv_a), 0);
        chk("reset_light", int'(light_a), 0);
        chk("reset_full", int'(full_a), 0);
        chk("reset_door_lock", int'(lock_a), 0);
        chk("reset_pulses", int'({en_a, ex_a, er_a}), 0);

        // Three entries with default parameters
        expect_ev(0, K_ENTRY, 1);
        entry_seq(0);
        chk("light_after_first_entry", int'(light_a), 1);
        expect_ev(0, K_ENTRY, 2);
        entry_seq(0);
        expect_ev(0, K_ENTRY, 3);
        entry_seq(0);
        chk("count_after_three_entries", int'(cv_a), 3);

        // Exits down to zero, then underflow
        expect_ev(0, K_EXIT, 2);
        exit_seq(0);
        expect_ev(0, K_EXIT, 1);
        exit_seq(0);
        expect_ev(0, K_EXIT, 0);
        exit_seq(0);
        chk("light_after_last_exit", int'(light_a), 0);
        expect_ev(0, K_ERR, 0);
        exit_seq(0);
        chk("count_after_underflow", int'(cv_a), 0);

        // Aborted entry: outer beam only
        phase(0, 1'b1, 1'b0, 10);
        phase(0, 1'b0, 1'b0, 10);
        chk("count_after_abort", int'(cv_a), 0);

        // A 2-cycle outer blip must not arm an entry; the following inner-only
        // pattern then reads as an aborted exit with no event.
        phase(0, 1'b1, 1'b0, 2);
        phase(0, 1'b0, 1'b1, 10);
        phase(0, 1'b0, 1'b0, 10);
        chk("count_after_blip", int'(cv_a), 0);

        // Simultaneous block from IDLE
        expect_ev(0, K_ERR, 0);
        phase(0, 1'b1, 1'b1, 10);
        phase(0, 1'b0, 1'b0, 10);

        // Reset asserted while in IN_B
        expect_ev(0, K_ENTRY, 1);
        entry_seq(0);
        phase(0, 1'b1, 1'b0, 10);
        phase(0, 1'b0, 1'b1, 10);
        rst_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midseq_reset_count", int'(cv_a), 0);
        chk("midseq_reset_light", int'(light_a), 0);
        chk("midseq_reset_pulses", int'({en_a, ex_a, er_a}), 0);
        rst_n[0] = 1'b1;
        phase(0, 1'b0, 1'b0, 12);
        chk("count_after_midseq_reset", int'(cv_a), 0);

        // clear on the commit edge (2+DEBOUNCE+1 edges after the inner release)
        expect_ev(0, K_ENTRY, 1);
        entry_seq(0);
        phase(0, 1'b1, 1'b0, 10);
        phase(0, 1'b0, 1'b1, 10);
        ir2[0] = 1'b0;
        repeat (5) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("count_on_clear_commit", int'(cv_a), 0);
        repeat (10) @(negedge clk);
        chk("count_after_clear_commit", int'(cv_a), 0);

        // Capacity 2 instance: fill, then saturate
        expect_ev(1, K_ENTRY, 1);
        entry_seq(1);
        chk("cap_full_at_one", int'(full_b), 0);
        expect_ev(1, K_ENTRY, 2);
        entry_seq(1);
        chk("cap_full_at_two", int'(full_b), 1);
        chk("cap_door_lock_at_two", int'(lock_b), 1);
        expect_ev(1, K_ERR, 2);
        entry_seq(1);
        chk("cap_count_after_saturation", int'(cv_b), 2);

        // Timeout with the outer beam held, then a normal exit proves return to IDLE
        expect_ev(1, K_ERR, 2);
        phase(1, 1'b1, 1'b0, 60);
        phase(1, 1'b0, 1'b0, 10);
        chk("count_after_timeout", int'(cv_b), 2);
        expect_ev(1, K_EXIT, 1);
        exit_seq(1);
        chk("cap_full_after_exit", int'(full_b), 0);
        chk("cap_light_after_exit", int'(light_b), 1);

        repeat (10) @(negedge clk);
        while (q_a.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL dut0_missing_event: got none, required %s count=%0d",
                     kname(q_a[0].kind), q_a[0].cnt);
            void'(q_a.pop_front());
        end
        while (q_b.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL dut1_missing_event: got none, required %s count=%0d",
                     kname(q_b[0].kind), q_b[0].cnt);
            void'(q_b.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
